// File: rtl/matrix_operand_loader.sv
// Collects eight 2-bit elements into packed 2x2 operand matrices A and B,
// then holds the pair until the downstream multiplier/adder stage accepts it.
module matrix_operand_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_data,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] a_mat,
  output logic [7:0] b_mat,
  output logic [2:0] elem_cnt,
  output logic [7:0] pair_cnt
);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_out_valid;
  logic       w_out_valid_nxt;
  logic [7:0] r_a_mat;
  logic [7:0] w_a_nxt;
  logic [7:0] r_b_mat;
  logic [7:0] w_b_nxt;
  logic [2:0] r_elem_cnt;
  logic [2:0] w_elem_cnt_nxt;
  logic [7:0] r_pair_cnt;
  logic [7:0] w_pair_cnt_nxt;
  logic       w_in_xfer;
  logic       w_out_xfer;

  assign in_ready   = (r_state == LOAD) && !rst;
  assign w_in_xfer  = in_valid && in_ready && !flush;
  assign w_out_xfer = r_out_valid && out_ready && !flush;

  // Next-state logic: flush outranks both handshakes; the 8th element enters HOLD.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_a_nxt         = r_a_mat;
    w_b_nxt         = r_b_mat;
    w_elem_cnt_nxt  = r_elem_cnt;
    w_pair_cnt_nxt  = r_pair_cnt;
    if (flush) begin
      w_state_nxt     = LOAD;
      w_out_valid_nxt = 1'b0;
      w_a_nxt         = 8'h00;
      w_b_nxt         = 8'h00;
      w_elem_cnt_nxt  = 3'd0;
    end else if (w_in_xfer) begin
      case (r_elem_cnt)
        3'd0:    w_a_nxt[7:6] = in_data;
        3'd1:    w_a_nxt[5:4] = in_data;
        3'd2:    w_a_nxt[3:2] = in_data;
        3'd3:    w_a_nxt[1:0] = in_data;
        3'd4:    w_b_nxt[7:6] = in_data;
        3'd5:    w_b_nxt[5:4] = in_data;
        3'd6:    w_b_nxt[3:2] = in_data;
        3'd7:    w_b_nxt[1:0] = in_data;
        default: w_a_nxt      = r_a_mat;
      endcase
      if (r_elem_cnt == 3'd7) begin
        w_state_nxt     = HOLD;
        w_out_valid_nxt = 1'b1;
        w_elem_cnt_nxt  = 3'd0;
      end else begin
        w_elem_cnt_nxt  = r_elem_cnt + 3'd1;
      end
    end else if (w_out_xfer) begin
      // Fields keep their old contents; new elements overwrite them one by one.
      w_state_nxt     = LOAD;
      w_out_valid_nxt = 1'b0;
      w_pair_cnt_nxt  = r_pair_cnt + 8'd1;
    end else begin
      w_state_nxt     = r_state;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_out_valid <= 1'b0;
      r_a_mat     <= 8'h00;
      r_b_mat     <= 8'h00;
      r_elem_cnt  <= 3'd0;
      r_pair_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_a_mat     <= w_a_nxt;
      r_b_mat     <= w_b_nxt;
      r_elem_cnt  <= w_elem_cnt_nxt;
      r_pair_cnt  <= w_pair_cnt_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign a_mat     = r_a_mat;
  assign b_mat     = r_b_mat;
  assign elem_cnt  = r_elem_cnt;
  assign pair_cnt  = r_pair_cnt;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Randomized and directed bench for matrix_operand_loader, checked against an
// element-list reference model of the loader.
module tb_matrix_operand_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a_mat;
  logic [7:0] b_mat;
  logic [2:0] elem_cnt;
  logic [7:0] pair_cnt;

  matrix_operand_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a_mat    (a_mat),
    .b_mat    (b_mat),
    .elem_cnt (elem_cnt),
    .pair_cnt (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the eight element slots in arrival order, a fill count,
  // whether a finished pair is waiting, and the number of delivered pairs.
  logic [1:0] m_e [8];
  int         m_n;
  bit         m_hold;
  int         m_pairs;

  int cyc     = 0;
  int last_ox = -1;
  int n_ox    = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_update();
    if (rst) begin
      m_hold = 1'b0; m_n = 0; m_pairs = 0;
      for (int i = 0; i < 8; i++) m_e[i] = 2'd0;
    end else if (flush) begin
      m_hold = 1'b0; m_n = 0;
      for (int i = 0; i < 8; i++) m_e[i] = 2'd0;
    end else if (!m_hold && in_valid) begin
      m_e[m_n] = in_data;
      if (m_n == 7) begin m_hold = 1'b1; m_n = 0; end
      else m_n = m_n + 1;
    end else if (m_hold && out_ready) begin
      m_hold = 1'b0;
      m_pairs = m_pairs + 1;
    end
  endtask

  task automatic check_outputs();
    chk_val("out_valid", 32'(out_valid), 32'(m_hold));
    chk_val("a_mat", 32'(a_mat), 32'({m_e[0], m_e[1], m_e[2], m_e[3]}));
    chk_val("b_mat", 32'(b_mat), 32'({m_e[4], m_e[5], m_e[6], m_e[7]}));
    chk_val("elem_cnt", 32'(elem_cnt), 32'(m_n));
    chk_val("pair_cnt", 32'(pair_cnt), 32'(m_pairs % 256));
  endtask

  task automatic step(input logic v, input logic [1:0] d, input logic f,
                      input logic r, input logic ordy);
    bit oxfer;
    in_valid = v; in_data = d; flush = f; rst = r; out_ready = ordy;
    @(negedge clk);
    chk_val("in_ready", 32'(in_ready), 32'(!m_hold && !r));
    oxfer = (out_valid === 1'b1) && ordy && !f && !r;
    @(posedge clk);
    model_update();
    cyc++;
    if (oxfer) begin
      n_ox++;
      if (last_ox >= 0) chk_val("pair_gap_ge9", 32'((cyc - last_ox) >= 9), 32'd1);
      last_ox = cyc;
    end
    #1;
    check_outputs();
  endtask

  logic [1:0] s31 [8];
  int         ph_start;

  initial begin
    s31 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd1};
    m_hold = 1'b0; m_n = 0; m_pairs = 0;
    for (int i = 0; i < 8; i++) m_e[i] = 2'd0;

    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Basic pair with out_ready high
    for (int i = 0; i < 8; i++) step(1'b1, s31[i], 1'b0, 1'b0, 1'b1);
    chk_val("a31", 32'(a_mat), 32'h1B);
    chk_val("b31", 32'(b_mat), 32'h4D);
    chk_val("ov31", 32'(out_valid), 32'd1);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    chk_val("pair31", 32'(pair_cnt), 32'd1);
    chk_val("rdy31", 32'(in_ready), 32'd1);

    // Backpressure in HOLD
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, s31[i], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
      chk_val("a32", 32'(a_mat), 32'h1B);
      chk_val("b32", 32'(b_mat), 32'h4D);
      chk_val("rdy32", 32'(in_ready), 32'd0);
      chk_val("pair32", 32'(pair_cnt), 32'd0);
    end
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    chk_val("pair32_rise", 32'(pair_cnt), 32'd1);

    // Flush mid-load, then reload
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    chk_val("cnt33", 32'(elem_cnt), 32'd0);
    chk_val("a33_clr", 32'(a_mat), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    chk_val("a33", 32'(a_mat), 32'hAA);
    chk_val("b33", 32'(b_mat), 32'hAA);

    // Reset during HOLD with out_ready high
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk_val("pair34", 32'(pair_cnt), 32'd0);
    chk_val("ov34", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk_val("rdy34", 32'(in_ready), 32'd1);

    // Flush coinciding with the 8th element
    for (int i = 0; i < 7; i++) step(1'b1, 2'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
    chk_val("ov36", 32'(out_valid), 32'd0);
    chk_val("cnt36", 32'(elem_cnt), 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk_val("ov36_next", 32'(out_valid), 32'd0);

    // 256 back-to-back pairs with random input gaps
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    ph_start = n_ox;
    for (int k = 0; k < 20000 && (n_ox - ph_start) < 256; k++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
    chk_val("pairs256", 32'(n_ox - ph_start), 32'd256);
    chk_val("pair_wrap", 32'(pair_cnt), 32'd0);

    // Fully random mix of flush, reset and backpressure
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 2) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
